// File: rtl/chess_pkg.sv
// Shared encodings for the chess turn controller: FSM states, turn polarity and
// J/K commands driven to the external turn flip-flop.
package chess_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RUN    = 3'd2,
    ST_SWITCH = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam logic TURN_WHITE = 1'b0;
  localparam logic TURN_BLACK = 1'b1;

  typedef logic [1:0] jk_t;
  localparam jk_t JK_HOLD   = 2'b00;
  localparam jk_t JK_CLR    = 2'b01;
  localparam jk_t JK_TOGGLE = 2'b11;

endpackage

// File: rtl/chess_player_timer.sv
// One player's countdown: load, floor-at-zero decrement, then saturating increment.
// Result registered one cycle after the command; zero flags the post-decrement value.
module chess_player_timer #(
  parameter int TW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  input  logic          add_inc,
  input  logic [TW-1:0] inc,
  output logic [TW-1:0] remaining,
  output logic          zero
);

  logic [TW-1:0] after_dec;
  logic [TW:0]   sum;

  always_comb begin
    after_dec = remaining;
    if (dec && (remaining != '0)) after_dec = remaining - 1'b1;
    sum = {1'b0, after_dec} + {1'b0, inc};
  end

  assign zero = (after_dec == '0);

  // The increment is applied on top of any tick in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_val;
    end else if (add_inc) begin
      remaining <= sum[TW] ? '1 : sum[TW-1:0];
    end else if (dec) begin
      remaining <= after_dec;
    end
  end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Game-flow controller driving the turn JK flip-flop, two Fischer clocks and the move counter.
// J/K registered one cycle after the deciding event; no backpressure, held buttons never repeat.
module chess_turn_ctrl
  import chess_pkg::*;
#(
  parameter int TW        = 8,
  parameter int INIT_TIME = 5,
  parameter int INC       = 2,
  parameter int MCW       = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           START,
  input  logic           WHITE_DONE,
  input  logic           BLACK_DONE,
  input  logic           TICK,
  input  logic           TURN_Q,
  output logic           TURN_J,
  output logic           TURN_K,
  output logic [TW-1:0]  WHITE_TIME,
  output logic [TW-1:0]  BLACK_TIME,
  output logic           FLAG_WHITE,
  output logic           FLAG_BLACK,
  output logic           RUNNING,
  output logic [MCW-1:0] MOVE_COUNT
);

  state_t state_q, state_d;
  jk_t    jk_q, jk_d;
  logic   arm_first_q;
  logic   turn_latch_q;
  logic   white_prev, black_prev;
  logic   white_edge, black_edge, mover_edge;
  logic   in_run, start_ok, flag_fall, move_ok;
  logic   white_zero, black_zero, active_zero;
  logic   white_dec, black_dec, white_add, black_add;

  assign white_edge  = WHITE_DONE & ~white_prev;
  assign black_edge  = BLACK_DONE & ~black_prev;
  assign in_run      = (state_q == ST_RUN);
  assign start_ok    = START & ((state_q == ST_IDLE) | (state_q == ST_OVER));
  assign mover_edge  = (TURN_Q == TURN_BLACK) ? black_edge : white_edge;
  assign active_zero = (TURN_Q == TURN_BLACK) ? black_zero : white_zero;
  assign white_dec   = in_run & TICK & (TURN_Q == TURN_WHITE);
  assign black_dec   = in_run & TICK & (TURN_Q == TURN_BLACK);
  // Flag-fall beats a move arriving in the same cycle.
  assign flag_fall   = in_run & TICK & active_zero;
  assign move_ok     = in_run & mover_edge & ~flag_fall;
  assign white_add   = move_ok & (TURN_Q == TURN_WHITE);
  assign black_add   = move_ok & (TURN_Q == TURN_BLACK);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: if (START) state_d = ST_ARM;
      // Leave ARM only once the force-white pulse has reached the flip-flop.
      ST_ARM:    if (!arm_first_q && (jk_q == JK_HOLD) && (TURN_Q == TURN_WHITE)) state_d = ST_RUN;
      ST_RUN:    if (flag_fall) state_d = ST_OVER;
                 else if (move_ok) state_d = ST_SWITCH;
      ST_SWITCH: if (TURN_Q != turn_latch_q) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    jk_d = JK_HOLD;
    if ((state_q == ST_ARM) && arm_first_q) jk_d = JK_CLR;
    if (move_ok) jk_d = JK_TOGGLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      jk_q         <= JK_HOLD;
      arm_first_q  <= 1'b0;
      turn_latch_q <= 1'b0;
      white_prev   <= 1'b0;
      black_prev   <= 1'b0;
      FLAG_WHITE   <= 1'b0;
      FLAG_BLACK   <= 1'b0;
      MOVE_COUNT   <= '0;
    end else begin
      jk_q        <= jk_d;
      arm_first_q <= start_ok;
      white_prev  <= WHITE_DONE;
      black_prev  <= BLACK_DONE;
      if (move_ok) turn_latch_q <= TURN_Q;
      if (start_ok) begin
        FLAG_WHITE <= 1'b0;
        FLAG_BLACK <= 1'b0;
        MOVE_COUNT <= '0;
      end else begin
        if (flag_fall && (TURN_Q == TURN_WHITE)) FLAG_WHITE <= 1'b1;
        if (flag_fall && (TURN_Q == TURN_BLACK)) FLAG_BLACK <= 1'b1;
        if (black_add) MOVE_COUNT <= MOVE_COUNT + 1'b1;
      end
    end
  end

  assign TURN_J  = jk_q[1];
  assign TURN_K  = jk_q[0];
  assign RUNNING = (state_q == ST_RUN) | (state_q == ST_SWITCH);

  chess_player_timer #(.TW(TW)) u_white (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (start_ok),
    .load_val  (TW'(INIT_TIME)),
    .dec       (white_dec),
    .add_inc   (white_add),
    .inc       (TW'(INC)),
    .remaining (WHITE_TIME),
    .zero      (white_zero)
  );

  chess_player_timer #(.TW(TW)) u_black (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (start_ok),
    .load_val  (TW'(INIT_TIME)),
    .dec       (black_dec),
    .add_inc   (black_add),
    .inc       (TW'(INC)),
    .remaining (BLACK_TIME),
    .zero      (black_zero)
  );

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Directed bench for chess_turn_ctrl with a behavioural JK turn flip-flop in the loop.
module tb_chess_turn_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       START = 1'b0;
  logic       WHITE_DONE = 1'b0;
  logic       BLACK_DONE = 1'b0;
  logic       TICK = 1'b0;
  logic       TURN_Q;
  logic       TURN_J, TURN_K;
  logic [7:0] WHITE_TIME, BLACK_TIME;
  logic       FLAG_WHITE, FLAG_BLACK, RUNNING;
  logic [7:0] MOVE_COUNT;

  int checks = 0;
  int errors = 0;
  int toggles;

  chess_turn_ctrl #(.TW(8), .INIT_TIME(5), .INC(2), .MCW(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .WHITE_DONE (WHITE_DONE),
    .BLACK_DONE (BLACK_DONE),
    .TICK       (TICK),
    .TURN_Q     (TURN_Q),
    .TURN_J     (TURN_J),
    .TURN_K     (TURN_K),
    .WHITE_TIME (WHITE_TIME),
    .BLACK_TIME (BLACK_TIME),
    .FLAG_WHITE (FLAG_WHITE),
    .FLAG_BLACK (FLAG_BLACK),
    .RUNNING    (RUNNING),
    .MOVE_COUNT (MOVE_COUNT)
  );

  always #5 CLK = ~CLK;

  // External turn flip-flop sharing RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) TURN_Q <= 1'b0;
    else begin
      case ({TURN_J, TURN_K})
        2'b01:   TURN_Q <= 1'b0;
        2'b10:   TURN_Q <= 1'b1;
        2'b11:   TURN_Q <= ~TURN_Q;
        default: TURN_Q <= TURN_Q;
      endcase
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_move(input bit black);
    if (black) BLACK_DONE = 1'b1; else WHITE_DONE = 1'b1;
    step(); step(); step();
    BLACK_DONE = 1'b0;
    WHITE_DONE = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset values and start-up sequence
    step(); step();
    check("rst_j", 32'(TURN_J), 0);
    check("rst_k", 32'(TURN_K), 0);
    check("rst_wtime", 32'(WHITE_TIME), 0);
    check("rst_run", 32'(RUNNING), 0);
    check("rst_mc", 32'(MOVE_COUNT), 0);
    RESET = 1'b0;
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    check("arm0_jk", 32'({TURN_J, TURN_K}), 0);
    check("start_wtime", 32'(WHITE_TIME), 5);
    check("start_btime", 32'(BLACK_TIME), 5);
    step();
    check("arm1_jk", 32'({TURN_J, TURN_K}), 1);
    step();
    check("arm2_jk", 32'({TURN_J, TURN_K}), 0);
    check("arm2_run", 32'(RUNNING), 0);
    check("arm2_q", 32'(TURN_Q), 0);
    step();
    check("run_on", 32'(RUNNING), 1);

    // 2: three ticks then a white move, then a black move
    TICK = 1'b1;
    step(); step(); step();
    TICK = 1'b0;
    check("tick3_wtime", 32'(WHITE_TIME), 2);
    WHITE_DONE = 1'b1;
    step();
    check("wmove_jk", 32'({TURN_J, TURN_K}), 3);
    check("wmove_wtime", 32'(WHITE_TIME), 4);
    step();
    check("wmove_jk_off", 32'({TURN_J, TURN_K}), 0);
    check("wmove_q", 32'(TURN_Q), 1);
    step();
    WHITE_DONE = 1'b0;
    check("switch_back_run", 32'(RUNNING), 1);
    step();
    BLACK_DONE = 1'b1;
    step();
    check("bmove_mc", 32'(MOVE_COUNT), 1);
    check("bmove_btime", 32'(BLACK_TIME), 7);
    step();
    check("bmove_q", 32'(TURN_Q), 0);
    step();
    BLACK_DONE = 1'b0;
    step();

    // 3: inactive button ignored, held button toggles once
    BLACK_DONE = 1'b1;
    step();
    BLACK_DONE = 1'b0;
    check("black_ignored_jk", 32'({TURN_J, TURN_K}), 0);
    WHITE_DONE = 1'b1;
    toggles = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (TURN_J && TURN_K) toggles++;
    end
    WHITE_DONE = 1'b0;
    step();
    check("hold_toggles", 32'(toggles), 1);
    check("hold_mc", 32'(MOVE_COUNT), 1);
    check("hold_q", 32'(TURN_Q), 1);
    check("hold_wtime", 32'(WHITE_TIME), 6);

    // 4: flag-fall beats a simultaneous move
    do_move(1'b1);
    check("pre_flag_mc", 32'(MOVE_COUNT), 2);
    check("pre_flag_btime", 32'(BLACK_TIME), 9);
    TICK = 1'b1;
    for (int i = 0; i < 5; i++) step();
    TICK = 1'b0;
    check("pre_flag_wtime", 32'(WHITE_TIME), 1);
    TICK = 1'b1;
    WHITE_DONE = 1'b1;
    step();
    TICK = 1'b0;
    WHITE_DONE = 1'b0;
    check("flag_wtime", 32'(WHITE_TIME), 0);
    check("flag_white", 32'(FLAG_WHITE), 1);
    check("flag_black", 32'(FLAG_BLACK), 0);
    check("flag_jk", 32'({TURN_J, TURN_K}), 0);
    check("flag_run", 32'(RUNNING), 0);
    check("flag_mc", 32'(MOVE_COUNT), 2);
    step();
    check("flag_q", 32'(TURN_Q), 0);
    TICK = 1'b1;
    step();
    TICK = 1'b0;
    step();
    check("over_wtime", 32'(WHITE_TIME), 0);
    check("over_btime", 32'(BLACK_TIME), 9);
    check("over_flag", 32'(FLAG_WHITE), 1);

    // 5: restart from OVER, drive black up to saturation
    START = 1'b1;
    step();
    START = 1'b0;
    check("restart_flag", 32'(FLAG_WHITE), 0);
    check("restart_mc", 32'(MOVE_COUNT), 0);
    check("restart_wtime", 32'(WHITE_TIME), 5);
    step(); step(); step();
    check("restart_run", 32'(RUNNING), 1);
    do_move(1'b0);
    TICK = 1'b1;
    step();
    TICK = 1'b0;
    check("sat_tick_btime", 32'(BLACK_TIME), 4);
    for (int i = 0; i < 125; i++) begin
      do_move(1'b1);
      do_move(1'b0);
    end
    check("sat_pre_btime", 32'(BLACK_TIME), 254);
    check("sat_pre_mc", 32'(MOVE_COUNT), 125);
    do_move(1'b1);
    check("sat_btime", 32'(BLACK_TIME), 255);
    check("sat_wtime", 32'(WHITE_TIME), 255);
    check("sat_mc", 32'(MOVE_COUNT), 126);
    check("sat_q", 32'(TURN_Q), 0);

    // 6: reset in the middle of a toggle pulse
    WHITE_DONE = 1'b1;
    step();
    check("mid_jk", 32'({TURN_J, TURN_K}), 3);
    #1 RESET = 1'b1;
    #1;
    check("arst_jk", 32'({TURN_J, TURN_K}), 0);
    check("arst_times", 32'({WHITE_TIME, BLACK_TIME}), 0);
    check("arst_mc", 32'(MOVE_COUNT), 0);
    check("arst_run", 32'(RUNNING), 0);
    check("arst_q", 32'(TURN_Q), 0);
    step();
    RESET = 1'b0;
    WHITE_DONE = 1'b0;
    step();
    check("idle_run", 32'(RUNNING), 0);
    START = 1'b1;
    step();
    START = 1'b0;
    check("rerun_times", 32'({WHITE_TIME, BLACK_TIME}), 32'h0505);
    step();
    check("rerun_jk", 32'({TURN_J, TURN_K}), 1);
    step(); step();
    check("rerun_run", 32'(RUNNING), 1);
    check("rerun_q", 32'(TURN_Q), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chess_turn_ctrl.md
Name: chess_turn_ctrl

Overview:
Game-flow controller that sits directly upstream of the turn flip-flop (JK flip-flop, Q=0 means white to move, Q=1 means black to move). It drives that flip-flop's J/K inputs and reads back its Q. It also runs two Fischer-increment countdown clocks, detects flag-fall, and counts full moves. Player move buttons and the time-base TICK arrive synchronous to CLK and already debounced.

Parameters:
TW, 8, width of each player's time counter in ticks.
INIT_TIME, 5, time loaded into both clocks on START; must be 1 to 2^TW-1.
INC, 2, ticks added to the mover's clock on each accepted move; 0 disables the increment.
MCW, 8, width of MOVE_COUNT.

Ports:
CLK  in  1  clock
RESET  in  1  reset, asynchronous, active-high
START  in  1  level; starts a new game from IDLE or OVER, ignored elsewhere
WHITE_DONE  in  1  white's move-complete button; rising edge is a move
BLACK_DONE  in  1  black's move-complete button; rising edge is a move
TICK  in  1  one-cycle time-base pulse
TURN_Q  in  1  Q of the turn flip-flop
TURN_J  out  1  J of the turn flip-flop, registered
TURN_K  out  1  K of the turn flip-flop, registered
WHITE_TIME  out  TW  white remaining ticks
BLACK_TIME  out  TW  black remaining ticks
FLAG_WHITE  out  1  white ran out of time, sticky until START or RESET
FLAG_BLACK  out  1  black ran out of time, sticky until START or RESET
RUNNING  out  1  high in RUN and SWITCH states
MOVE_COUNT  out  MCW  completed full moves, counted on black moves, wraps modulo 2^MCW

Behaviour:
- Reset (async): all outputs 0, state IDLE, edge-detect registers 0. The turn flip-flop shares RESET, so Q=0.
- States: IDLE, ARM, RUN, SWITCH, OVER.
- IDLE/OVER, START=1:
  - Load both clocks with INIT_TIME.
  - Clear flags and MOVE_COUNT.
  - Go to ARM.
- ARM:
  - First cycle in ARM: J=0, K=1 (force white).
  - Later cycles: J=K=0.
  - Go to RUN on the first cycle after the first ARM cycle with TURN_Q=0; otherwise stay in ARM.
  - Latency: START sampled at edge n, J/K=0/1 during cycle n+1, Q=0 by n+2, RUNNING=1 from n+3.
- RUN:
  - Active player = TURN_Q.
  - A rising edge on the active player's button is a valid move: J=K=1 for exactly one cycle (registered, next cycle), mover's clock += INC saturating at 2^TW-1, go to SWITCH.
  - If the mover is black, MOVE_COUNT += 1.
  - A button edge from the inactive player is ignored.
  - Holding a button produces no repeat.
- SWITCH:
  - Latch the pre-move TURN_Q value. J=K=0 after the single toggle cycle.
  - Return to RUN when TURN_Q differs from the latched value.
  - TICK and button edges are ignored in SWITCH.
- TICK in RUN: the active player's clock -= 1.
  - If this makes it 0, set that player's flag and go to OVER.
  - Clocks never go below 0.
- TICK and valid move in the same RUN cycle:
  - Apply the tick first.
  - If it reaches 0, flag-fall wins: no toggle, no increment, no move count.
  - Otherwise the move is accepted with the increment applied to the post-tick value.
- OVER: RUNNING=0, clocks frozen, J=K=0.
- Outside RUN, TICK has no effect; clocks hold.
- RESET mid-operation (any state, including during a J/K pulse) aborts immediately to reset values.

Decomposition:
- Shared package chess_pkg:
  - State encoding.
  - Turn constants TURN_WHITE=1'b0, TURN_BLACK=1'b1.
  - J/K command constants: HOLD=00, CLR=01, TOGGLE=11.
- Sub-module chess_player_timer (parameter TW), instantiated twice.
  - Inputs: load, load value, dec, add_inc, INC.
  - Outputs: time, zero.
  - Performs the saturating add and floor-at-zero decrement.

Test Plan:
1. Defaults, RESET then START pulse -> TURN_J/K=0/1 for exactly one cycle; RUNNING=1 three cycles after START; WHITE_TIME=BLACK_TIME=5.
2. RUN, white to move, 3 TICKs then WHITE_DONE rise -> WHITE_TIME=2 then 4; J=K=1 one cycle; TURN_Q becomes 1; state back to RUN. Then BLACK_DONE rise -> MOVE_COUNT=1 and TURN_Q=0.
3. White to move, BLACK_DONE rise and WHITE_DONE held high for 10 cycles after its first edge -> exactly one toggle, black edge ignored, MOVE_COUNT unchanged.
4. WHITE_TIME=1, TICK and WHITE_DONE rise in the same cycle -> WHITE_TIME=0, FLAG_WHITE=1, J=K=0, OVER, RUNNING=0. A further TICK changes nothing.
5. TW=8, INC=2, BLACK_TIME=254, black valid move without TICK -> BLACK_TIME=255 (saturated).
6. RESET asserted during SWITCH while J=K=1 -> all outputs 0 immediately, state IDLE. A subsequent START restarts with 5/5 and white to move.
